// File: rtl/gxb_tx_rate_seq_if.sv
// rtl/gxb_tx_rate_seq_if.sv - signal bundle between the TX rate sequencer and its neighbours
//
// Groups the rate-detect handshake (rate_req/rate_code/rate_ack), the
// reconfiguration master handshake (reconfig_start/reconfig_rate/reconfig_busy),
// the TX reset controller side (xcvr_reset/pll_select/tx_ready/tx_cal_busy/
// pll_locked) and the status outputs (link_up/busy/fail/retry_cnt).
//   master : the sequencer itself
//   slave  : the surrounding logic (rate detect, reset controller, reconfig)

interface gxb_tx_rate_seq_if #(
  parameter int LANES = 4
);

  logic             rate_req;
  logic [1:0]       rate_code;
  logic             rate_ack;
  logic             xcvr_reset;
  logic             pll_select;
  logic             reconfig_start;
  logic [1:0]       reconfig_rate;
  logic             reconfig_busy;
  logic             pll_locked;
  logic [LANES-1:0] tx_ready;
  logic [LANES-1:0] tx_cal_busy;
  logic             link_up;
  logic             busy;
  logic             fail;
  logic [1:0]       retry_cnt;

  modport master (
    input  rate_req, rate_code, reconfig_busy, pll_locked, tx_ready, tx_cal_busy,
    output rate_ack, xcvr_reset, pll_select, reconfig_start, reconfig_rate,
           link_up, busy, fail, retry_cnt
  );

  modport slave (
    output rate_req, rate_code, reconfig_busy, pll_locked, tx_ready, tx_cal_busy,
    input  rate_ack, xcvr_reset, pll_select, reconfig_start, reconfig_rate,
           link_up, busy, fail, retry_cnt
  );

endinterface

// File: rtl/gxb_tx_rate_seq.sv
// rtl/gxb_tx_rate_seq.sv - GXB TX bring-up and TMDS rate-change sequencer
//
// Holds the TX reset controller in reset, selects the TX PLL, launches a
// reconfiguration for the active rate, waits for calibration, releases reset
// and watches tx_ready/pll_locked with a timeout and bounded retry.
//
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : gxb_tx_rate_seq_if.master
//           in : rate_req, rate_code, reconfig_busy, pll_locked, tx_ready, tx_cal_busy
//           out: rate_ack, xcvr_reset, pll_select, reconfig_start, reconfig_rate,
//                link_up, busy, fail, retry_cnt
// All outputs are registered.

module gxb_tx_rate_seq #(
  parameter int LANES           = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int READY_TIMEOUT   = 65535,
  parameter int MAX_RETRY       = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  gxb_tx_rate_seq_if.master    bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(READY_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(READY_TIMEOUT);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [LANES-1:0]  ALL_LANES = '1;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RECFG,
    ST_WAIT_CAL,
    ST_WAIT_READY,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rate_q, rate_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d, to_inc;
  logic [1:0]         retry_q, retry_d;

  logic               xcvr_reset_q, xcvr_reset_d;
  logic               pll_select_q, pll_select_d;
  logic [1:0]         reconfig_rate_q, reconfig_rate_d;
  logic               start_q, start_d;
  logic               ack_q, ack_d;
  logic               link_up_q, link_up_d;
  logic               busy_q, busy_d;
  logic               fail_q, fail_d;

  logic               lanes_ok;
  logic               cal_done;

  assign lanes_ok = (bus.tx_ready == ALL_LANES) && bus.pll_locked;
  assign cal_done = (bus.tx_cal_busy == '0);

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    hold_cnt_d = '0;
    to_cnt_d   = '0;
    to_inc     = to_cnt_q + TO_W'(1);
    retry_d    = retry_q;
    ack_d      = 1'b0;
    start_d    = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RECFG;
          start_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      // start_q is high only in the first RECFG cycle; reconfig_busy may not
      // have risen yet, so it is only trusted from the second cycle on.
      ST_RECFG: begin
        if (!start_q && !bus.reconfig_busy) begin
          state_d = ST_WAIT_CAL;
        end
      end

      ST_WAIT_CAL: begin
        if (cal_done) begin
          state_d = ST_WAIT_READY;
        end
      end

      // Ready wins over a timeout landing in the same cycle.
      ST_WAIT_READY: begin
        if (lanes_ok) begin
          state_d = ST_RUN;
        end else if (to_inc == TO_LIMIT) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          to_cnt_d = to_inc;
        end
      end

      // A new rate request beats lock loss in the same cycle.
      ST_RUN: begin
        if (bus.rate_req) begin
          ack_d   = 1'b1;
          rate_d  = bus.rate_code;
          retry_d = 2'd0;
          state_d = ST_HOLD;
        end else if (!lanes_ok) begin
          retry_d = 2'd0;
          state_d = ST_HOLD;
        end
      end

      ST_FAIL: begin
        if (bus.rate_req) begin
          ack_d   = 1'b1;
          rate_d  = bus.rate_code;
          retry_d = 2'd0;
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    xcvr_reset_d = (state_d == ST_HOLD) || (state_d == ST_RECFG) ||
                   (state_d == ST_WAIT_CAL) || (state_d == ST_FAIL);
    busy_d       = (state_d == ST_HOLD) || (state_d == ST_RECFG) ||
                   (state_d == ST_WAIT_CAL) || (state_d == ST_WAIT_READY);
    link_up_d    = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);

    // PLL select and reconfig rate only move while heading into HOLD, so the
    // transceiver is always in reset when they change.
    pll_select_d    = pll_select_q;
    reconfig_rate_d = reconfig_rate_q;
    if (state_d == ST_HOLD) begin
      pll_select_d    = rate_d[1];
      reconfig_rate_d = rate_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_HOLD;
      rate_q          <= 2'd0;
      hold_cnt_q      <= '0;
      to_cnt_q        <= '0;
      retry_q         <= 2'd0;
      xcvr_reset_q    <= 1'b1;
      pll_select_q    <= 1'b0;
      reconfig_rate_q <= 2'd0;
      start_q         <= 1'b0;
      ack_q           <= 1'b0;
      link_up_q       <= 1'b0;
      busy_q          <= 1'b1;
      fail_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rate_q          <= rate_d;
      hold_cnt_q      <= hold_cnt_d;
      to_cnt_q        <= to_cnt_d;
      retry_q         <= retry_d;
      xcvr_reset_q    <= xcvr_reset_d;
      pll_select_q    <= pll_select_d;
      reconfig_rate_q <= reconfig_rate_d;
      start_q         <= start_d;
      ack_q           <= ack_d;
      link_up_q       <= link_up_d;
      busy_q          <= busy_d;
      fail_q          <= fail_d;
    end
  end

  assign bus.rate_ack       = ack_q;
  assign bus.xcvr_reset     = xcvr_reset_q;
  assign bus.pll_select     = pll_select_q;
  assign bus.reconfig_start = start_q;
  assign bus.reconfig_rate  = reconfig_rate_q;
  assign bus.link_up        = link_up_q;
  assign bus.busy           = busy_q;
  assign bus.fail           = fail_q;
  assign bus.retry_cnt      = retry_q;

endmodule

// File: tb/tb_gxb_tx_rate_seq.sv
// tb/tb_gxb_tx_rate_seq.sv - self-checking bench for gxb_tx_rate_seq

module tb_gxb_tx_rate_seq;

  localparam int LANES = 4;
  localparam int HOLD  = 16;
  localparam int RT    = 8;
  localparam int MAXR  = 3;
  localparam int NV    = 19;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  gxb_tx_rate_seq_if #(.LANES(LANES)) bus();

  gxb_tx_rate_seq #(
    .LANES(LANES),
    .RST_HOLD_CYCLES(HOLD),
    .READY_TIMEOUT(RT),
    .MAX_RETRY(MAXR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // {xcvr_reset, reconfig_start, link_up, busy, fail, rate_ack, pll_select, reconfig_rate, retry_cnt}
  logic [10:0] actv;
  assign actv = {bus.xcvr_reset, bus.reconfig_start, bus.link_up, bus.busy, bus.fail,
                 bus.rate_ack, bus.pll_select, bus.reconfig_rate, bus.retry_cnt};

  typedef struct {
    logic        rst;
    logic        rq;
    logic [1:0]  cd;
    logic        rb;
    logic        lk;
    logic [3:0]  rdy;
    logic [3:0]  cal;
    int          reps;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[NV];

  function automatic logic [10:0] ex(input logic xr, input logic st, input logic lu,
                                     input logic bz, input logic fl, input logic ak,
                                     input logic [1:0] rr, input logic [1:0] rc);
    return {xr, st, lu, bz, fl, ak, rr[1], rr, rc};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic rq, input logic [1:0] cd,
                               input logic rb, input logic lk, input logic [3:0] rdy,
                               input logic [3:0] cal, input int reps, input logic [10:0] e);
    vec_t v;
    v.rst = rst; v.rq = rq; v.cd = cd; v.rb = rb; v.lk = lk;
    v.rdy = rdy; v.cal = cal; v.reps = reps; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [10:0] e);
    checks++;
    if (actv !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (xr st lu bz fl ak ps rr rc)", name, cyc, actv, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [1:0] cd, input logic rb, input logic lk,
                       input logic [3:0] rdy, input logic [3:0] cal);
    bus.rate_req      = rq;
    bus.rate_code     = cd;
    bus.reconfig_busy = rb;
    bus.pll_locked    = lk;
    bus.tx_ready      = rdy;
    bus.tx_cal_busy   = cal;
  endtask

  task automatic drive_bad_ready();
    logic [3:0] r;
    logic       l;
    r = 4'($urandom_range(0, 15));
    l = 1'($urandom_range(0, 1));
    if (r == 4'hF && l) begin
      if ($urandom_range(0, 1) == 1) r[$urandom_range(0, 3)] = 1'b0;
      else l = 1'b0;
    end
    bus.tx_ready   = r;
    bus.pll_locked = l;
  endtask

  // One pass HOLD..WAIT_READY starting at HOLD cycle 0. Timeline from the
  // rules: HOLD cycles [0,HOLD), RECFG 2+b cycles, WAIT_CAL c+1 cycles,
  // WAIT_READY from w; ready at w+r enters RUN, otherwise RT cycles then retry.
  task automatic attempt(input logic [1:0] rate, input logic ack0, input logic [1:0] retry,
                         input bit ok, input int rfix);
    int b, c, r, w, last;
    b = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    r = (rfix >= 0) ? rfix : int'($urandom_range(0, RT - 1));
    w = HOLD + 3 + b + c;
    last = ok ? w + r : w + RT - 1;
    for (int cyc = 0; cyc <= last; cyc++) begin
      reset         = 1'b1;
      bus.rate_req  = 1'($urandom_range(0, 1));
      bus.rate_code = 2'($urandom_range(0, 3));
      if (cyc >= HOLD + 1 && cyc < HOLD + 1 + b) bus.reconfig_busy = 1'b1;
      else if (cyc == HOLD + 1 + b)              bus.reconfig_busy = 1'b0;
      else                                       bus.reconfig_busy = 1'($urandom_range(0, 1));
      if (cyc >= HOLD + 2 + b && cyc < HOLD + 2 + b + c) bus.tx_cal_busy = 4'($urandom_range(1, 15));
      else if (cyc == HOLD + 2 + b + c)                  bus.tx_cal_busy = 4'h0;
      else                                               bus.tx_cal_busy = 4'($urandom_range(0, 15));
      if (cyc < w) begin
        bus.tx_ready   = 4'($urandom_range(0, 15));
        bus.pll_locked = 1'($urandom_range(0, 1));
      end else if (ok && cyc == w + r) begin
        bus.tx_ready   = 4'hF;
        bus.pll_locked = 1'b1;
      end else begin
        drive_bad_ready();
      end
      chk("seq", cyc, ex(cyc < w, cyc == HOLD, 1'b0, 1'b1, 1'b0, ack0 && cyc == 0, rate, retry));
      tick();
    end
    if (ok)
      chk("run_entry", last + 1, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rate, retry));
    else if (int'(retry) < MAXR)
      chk("retry_entry", last + 1, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rate, retry + 2'd1));
    else
      chk("fail_entry", last + 1, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rate, retry));
  endtask

  // nt timeouts before success; more than MAXR timeouts ends in FAIL.
  task automatic do_seq(input logic [1:0] rate, input logic ack0, input int nt, output bit failed);
    failed = 1'b0;
    for (int k = 0; k <= MAXR; k++) begin
      attempt(rate, ack0 && k == 0, 2'(k), k == nt,
              (k == nt && $urandom_range(0, 3) == 0) ? RT - 1 : -1);
      if (k == nt) break;
      if (k == MAXR) failed = 1'b1;
    end
  endtask

  // exk: 0 = rate request, 1 = lock loss, 2 = both in the same cycle
  task automatic run_phase(input logic [1:0] rate, input logic [1:0] retry, input int n,
                           input int exk, input logic [1:0] code,
                           output logic [1:0] nrate, output logic nack);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 4'hF,
            4'($urandom_range(0, 15)));
      chk("run", i, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rate, retry));
      tick();
    end
    bus.rate_req      = (exk != 1);
    bus.rate_code     = code;
    bus.reconfig_busy = 1'($urandom_range(0, 1));
    if (exk == 0) begin
      bus.tx_ready   = 4'hF;
      bus.pll_locked = 1'b1;
    end else begin
      drive_bad_ready();
    end
    chk("run_exit", n, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rate, retry));
    tick();
    nrate = (exk == 1) ? rate : code;
    nack  = (exk != 1);
  endtask

  task automatic fail_phase(input logic [1:0] rate, input int n, input logic [1:0] code);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("fail_hold", i, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rate, 2'(MAXR)));
      tick();
    end
    bus.rate_req  = 1'b1;
    bus.rate_code = code;
    chk("fail_req", n, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rate, 2'(MAXR)));
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rst_v, hold0_v, hold2_v;
    logic [1:0]  rate, nrate, code;
    logic        ack, nack;
    bit          failed;
    int          nt;

    rst_v   = ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    hold0_v = rst_v;
    hold2_v = ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0);

    vt[0]  = mkv(0, 1, 2'd3, 1, 1, 4'hF, 4'h0,  3, rst_v);
    vt[1]  = mkv(1, 0, 2'd0, 1, 1, 4'hF, 4'h0, 15, hold0_v);
    vt[2]  = mkv(1, 0, 2'd0, 1, 1, 4'hF, 4'h0,  1, ex(1, 1, 0, 1, 0, 0, 2'd0, 2'd0));
    vt[3]  = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  1, hold0_v);
    vt[4]  = mkv(1, 0, 2'd0, 1, 1, 4'hF, 4'h0,  3, hold0_v);
    vt[5]  = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h5,  1, hold0_v);
    vt[6]  = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h5,  2, hold0_v);
    vt[7]  = mkv(1, 0, 2'd0, 0, 0, 4'h0, 4'h0,  1, ex(0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
    vt[8]  = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  1, ex(0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
    vt[9]  = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  3, ex(0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
    vt[10] = mkv(1, 1, 2'd2, 0, 1, 4'hF, 4'h0,  1, ex(1, 0, 0, 1, 0, 1, 2'd2, 2'd0));
    vt[11] = mkv(1, 1, 2'd1, 1, 1, 4'hF, 4'h0,  1, hold2_v);
    vt[12] = mkv(1, 0, 2'd0, 1, 1, 4'hF, 4'h0, 14, hold2_v);
    vt[13] = mkv(1, 0, 2'd0, 1, 1, 4'hF, 4'h0,  1, ex(1, 1, 0, 1, 0, 0, 2'd2, 2'd0));
    vt[14] = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  1, hold2_v);
    vt[15] = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  1, hold2_v);
    vt[16] = mkv(1, 0, 2'd0, 0, 1, 4'h0, 4'h0,  1, ex(0, 0, 0, 1, 0, 0, 2'd2, 2'd0));
    vt[17] = mkv(1, 0, 2'd0, 0, 1, 4'hF, 4'h0,  1, ex(0, 0, 1, 0, 0, 0, 2'd2, 2'd0));
    vt[18] = mkv(1, 0, 2'd0, 0, 0, 4'hF, 4'h0,  1, hold2_v);

    reset = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0);

    for (int i = 0; i < NV; i++) begin
      for (int rep = 0; rep < vt[i].reps; rep++) begin
        reset = vt[i].rst;
        drive(vt[i].rq, vt[i].cd, vt[i].rb, vt[i].lk, vt[i].rdy, vt[i].cal);
        tick();
        chk($sformatf("vec%0d", i), rep, vt[i].exp);
      end
    end

    // Lock-loss HOLD at rate 2 -> timeout, retry 1
    attempt(2'd2, 1'b0, 2'd0, 1'b0, -1);

    // Reset in the first RECFG cycle abandons the sequence
    for (int i = 0; i < HOLD; i++) begin
      reset = 1'b1;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 4'hF, 4'h0);
      chk("rst_hold", i, ex(1, 0, 0, 1, 0, 0, 2'd2, 2'd1));
      tick();
    end
    chk("rst_recfg", HOLD, ex(1, 1, 0, 1, 0, 0, 2'd2, 2'd1));
    reset = 1'b0;
    bus.reconfig_busy = 1'b1;
    tick();
    chk("rst_vals", 0, rst_v);
    attempt(2'd0, 1'b0, 2'd0, 1'b1, -1);

    // Lock loss and request in the same cycle: request wins
    run_phase(2'd0, 2'd0, 3, 2, 2'd3, nrate, nack);

    // Exhaust retries, then recover from FAIL with code 1
    do_seq(nrate, nack, MAXR + 1, failed);
    checks++;
    if (!failed) begin
      errors++;
      $display("FAIL fail_expected got=%0d exp=1", failed);
    end
    fail_phase(nrate, 4, 2'd1);
    rate = 2'd1;
    ack  = 1'b1;

    for (int s = 0; s < 30; s++) begin
      nt = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, MAXR + 1));
      do_seq(rate, ack, nt, failed);
      code = 2'($urandom_range(0, 3));
      if (failed) begin
        fail_phase(rate, int'($urandom_range(0, 3)), code);
        rate = code;
        ack  = 1'b1;
      end else begin
        run_phase(rate, 2'(nt), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  code, nrate, nack);
        rate = nrate;
        ack  = nack;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
